// File: rtl/dmem_stage.sv
// dmem_stage: M-stage data memory for the pipelined core.
// Word-organised RAM with a configurable number of wait states, word and
// byte stores, word loads, misalignment flagging and saturating load/store
// event counters. MemBusyM lets the hazard unit freeze the pipe while an
// access is in flight.
module dmem_stage #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic        ByteOpM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemBusyM,
    output logic        MisalignM,
    output logic [15:0] LoadCount,
    output logic [15:0] StoreCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam bit         SINGLE_CYCLE = (WAIT_CYCLES == 0);
    localparam bit         ONE_WAIT     = (WAIT_CYCLES == 1);
    localparam logic [3:0] WAIT_LOAD    = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              byte_q;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [15:0]       ld_cnt_q, st_cnt_q;

    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] acc_idx;
    logic [1:0]        acc_lane;
    logic [31:0]       acc_data;
    logic              acc_we;
    logic              acc_byte;
    logic              complete;

    logic              unused_addr_hi;

    assign req_idx        = ALUOutM[ADDR_W+1:2];
    assign unused_addr_hi = ^ALUOutM[31:ADDR_W+2];
    assign LoadCount      = ld_cnt_q;
    assign StoreCount     = st_cnt_q;

    // State register and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the request cycle is the first stall cycle, so the
    // WAIT leg runs WAIT_CYCLES-1 cycles and exits as the count steps 1 -> 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (MemReqM && !SINGLE_CYCLE) begin
                    if (ONE_WAIT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!MemReqM) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and selection of the access completing this cycle
    always_comb begin
        acc_idx   = req_idx;
        acc_lane  = ALUOutM[1:0];
        acc_data  = WriteDataM;
        acc_we    = MemWriteM;
        acc_byte  = ByteOpM;
        complete  = 1'b0;
        MemBusyM  = 1'b0;
        case (state_q)
            S_IDLE: begin
                complete = MemReqM && SINGLE_CYCLE;
                MemBusyM = MemReqM && !SINGLE_CYCLE;
            end
            S_WAIT: MemBusyM = 1'b1;
            S_DONE: begin
                acc_idx  = idx_q;
                acc_lane = lane_q;
                acc_data = wdata_q;
                acc_we   = we_q;
                acc_byte = byte_q;
                complete = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            MemBusyM = 1'b0;
        end
        MisalignM = complete && !reset && !acc_byte && (acc_lane != 2'b00);
        ReadDataM = mem_q[acc_idx];
    end

    // Capture the request so input changes during the stall are harmless
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
        end else if (state_q == S_IDLE && MemReqM) begin
            idx_q   <= req_idx;
            lane_q  <= ALUOutM[1:0];
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
            byte_q  <= ByteOpM;
        end
    end

    // Saturating completed-load and completed-store counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else if (complete) begin
            if (acc_we) begin
                if (st_cnt_q != '1) begin
                    st_cnt_q <= st_cnt_q + 16'd1;
                end
            end else begin
                if (ld_cnt_q != '1) begin
                    ld_cnt_q <= ld_cnt_q + 16'd1;
                end
            end
        end
    end

    // Storage array: commit word or single little-endian byte lane
    always_ff @(posedge clk) begin
        if (complete && acc_we) begin
            if (acc_byte) begin
                mem_q[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_data[7:0];
            end else begin
                mem_q[acc_idx] <= acc_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: randomized self-checking bench for dmem_stage with three
// instances (0, 2 and 3 wait states) checked every cycle against a
// transaction-level model.
module tb_dmem_stage;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        req  [3];
    logic        we   [3];
    logic        bo   [3];
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic [31:0] rd   [3];
    logic        busy [3];
    logic        mis  [3];
    logic [15:0] ldc  [3];
    logic [15:0] stc  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_stage #(
            .DEPTH_WORDS(64),
            .ADDR_W(6),
            .WAIT_CYCLES(g == 0 ? 0 : g + 1)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .MemReqM(req[g]),
            .MemWriteM(we[g]),
            .ByteOpM(bo[g]),
            .ALUOutM(addr[g]),
            .WriteDataM(wd[g]),
            .ReadDataM(rd[g]),
            .MemBusyM(busy[g]),
            .MisalignM(mis[g]),
            .LoadCount(ldc[g]),
            .StoreCount(stc[g])
        );
    end

    // Model state (written by the driver only)
    logic [31:0] mem_m [3][64];
    int unsigned ld_m [3];
    int unsigned st_m [3];
    bit          exp_busy [3];
    bit          exp_mis  [3];
    bit          exp_rdv  [3];
    logic [31:0] exp_rd   [3];

    // Literal expectations posted by the driver, checked by the compare process
    string       lit_name;
    int          lit_k;
    logic [31:0] lit_act;
    logic [31:0] lit_exp;
    int          lit_seq  = 0;
    int          lit_done = 0;

    // Observations (written by the compare process only)
    logic [31:0] rd_seen    [3];
    int          busy_seen  [3];
    int          mis_seen   [3];
    int          errs   = 0;
    int          checks = 0;

    function automatic int wc(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, {31'b0, busy[k]}, {31'b0, exp_busy[k]});
            chk("misalign", k, {31'b0, mis[k]}, {31'b0, exp_mis[k]});
            chk("loadcount", k, {16'b0, ldc[k]}, ld_m[k]);
            chk("storecount", k, {16'b0, stc[k]}, st_m[k]);
            if (exp_rdv[k]) begin
                chk("rdata", k, rd[k], exp_rd[k]);
                rd_seen[k] = rd[k];
            end
            if (busy[k]) busy_seen[k]++;
            if (mis[k])  mis_seen[k]++;
        end
        if (lit_seq != lit_done) begin
            chk(lit_name, lit_k, lit_act, lit_exp);
            lit_done = lit_seq;
        end
    end

    task automatic post(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        lit_name = name;
        lit_k    = k;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int k);
        req[k]      = 1'b0;
        exp_busy[k] = 1'b0;
        exp_mis[k]  = 1'b0;
        exp_rdv[k]  = 1'b0;
    endtask

    // One access on instance k; ab > 0 drops MemReqM in that wait-cycle index
    task automatic access(input int k, input bit w, input bit b, input logic [31:0] a,
                          input logic [31:0] d, input int ab);
        int W;
        int idx;
        bit m;
        bit aborted;
        W       = wc(k);
        idx     = int'(a[7:2]);
        m       = !b && (a[1:0] != 2'b00);
        aborted = 1'b0;
        req[k] = 1'b1; we[k] = w; bo[k] = b; addr[k] = a; wd[k] = d;
        if (W == 0) begin
            exp_busy[k] = 1'b0; exp_mis[k] = m; exp_rdv[k] = !w; exp_rd[k] = mem_m[k][idx];
        end else begin
            exp_busy[k] = 1'b1; exp_mis[k] = 1'b0; exp_rdv[k] = 1'b0;
            for (int c = 1; c <= W; c++) begin
                @(posedge clk); #1;
                if (aborted) break;
                if (c < W) begin
                    addr[k] = $urandom; wd[k] = $urandom;
                    we[k] = 1'($urandom); bo[k] = 1'($urandom);
                    exp_busy[k] = 1'b1;
                    if (c == ab) begin
                        req[k]  = 1'b0;
                        aborted = 1'b1;
                    end
                end else begin
                    exp_busy[k] = 1'b0; exp_mis[k] = m; exp_rdv[k] = !w; exp_rd[k] = mem_m[k][idx];
                end
            end
        end
        if (!aborted) begin
            @(posedge clk);
            if (w) begin
                if (b) mem_m[k][idx][8*int'(a[1:0]) +: 8] = d[7:0];
                else   mem_m[k][idx] = d;
                if (st_m[k] < 32'hFFFF) st_m[k]++;
            end else begin
                if (ld_m[k] < 32'hFFFF) ld_m[k]++;
            end
            #1;
        end
        go_idle(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        int m0;
        logic [31:0] d;
        for (int k = 0; k < 3; k++) begin
            ld_m[k] = 0; st_m[k] = 0;
            we[k] = 1'b0; bo[k] = 1'b0; addr[k] = '0; wd[k] = '0;
            go_idle(k);
        end
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        post("reset_loadcount", 0, {16'b0, ldc[0]}, 32'd0);
        post("reset_busy", 2, {31'b0, busy[2]}, 32'd0);

        // Single-cycle store then load
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 0);
        access(0, 0, 0, 32'h10, 32'h0, 0);
        post("t1_rdata", 0, rd_seen[0], 32'hDEADBEEF);
        post("t1_loadcount", 0, {16'b0, ldc[0]}, 32'd1);
        post("t1_storecount", 0, {16'b0, stc[0]}, 32'd1);

        // Fill every word of every instance so later loads have known data
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 64; i++)
                access(k, 1, 0, 32'(i * 4), $urandom, 0);

        // Two wait states: held load, then a chained new access
        access(1, 1, 0, 32'h10, 32'hDEADBEEF, 0);
        b0 = busy_seen[1];
        access(1, 0, 0, 32'h10, 32'h0, 0);
        post("t2_rdata", 1, rd_seen[1], 32'hDEADBEEF);
        post("t2_busycycles", 1, 32'(busy_seen[1] - b0), 32'd2);
        b0 = busy_seen[1];
        access(1, 0, 0, 32'h10, 32'h0, 0);
        access(1, 0, 0, 32'h10, 32'h0, 0);
        post("t2_chained_busy", 1, 32'(busy_seen[1] - b0), 32'd4);

        // Byte lanes and misalignment / aliasing on every instance
        for (int k = 0; k < 3; k++) begin
            access(k, 1, 0, 32'h20, 32'h0, 0);
            d = $urandom; d[7:0] = 8'h11;
            access(k, 1, 1, 32'h21, d, 0);
            d = $urandom; d[7:0] = 8'h22;
            access(k, 1, 1, 32'h23, d, 0);
            access(k, 0, 0, 32'h20, 32'h0, 0);
            post("t3_bytelanes", k, rd_seen[k], 32'h22001100);
            m0 = mis_seen[k];
            access(k, 1, 0, 32'h06, 32'h12345678, 0);
            post("t4_mispulse", k, 32'(mis_seen[k] - m0), 32'd1);
            access(k, 0, 0, 32'h104, 32'h0, 0);
            post("t4_alias", k, rd_seen[k], 32'h12345678);
            access(k, 0, 0, 32'h04, 32'h0, 0);
            post("t4_aligned", k, rd_seen[k], 32'h12345678);
        end

        // Randomized traffic with occasional aborts and idle gaps
        for (int n = 0; n < 400; n++) begin
            int k;
            int ab;
            k  = int'($urandom_range(0, 2));
            ab = (wc(k) >= 2 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, wc(k) - 1)) : 0;
            access(k, 1'($urandom), 1'($urandom), $urandom, $urandom, ab);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Aborted stores leave memory and counters alone
        for (int k = 1; k < 3; k++) begin
            access(k, 1, 0, 32'h30, 32'hCAFEF00D, 0);
            b0 = int'(stc[k]);
            access(k, 1, 0, 32'h30, 32'h55555555, wc(k) - 1);
            post("abort_storecount", k, {16'b0, stc[k]}, 32'(b0));
            access(k, 0, 0, 32'h30, 32'h0, 0);
            post("abort_nowrite", k, rd_seen[k], 32'hCAFEF00D);
        end

        // Reset in the middle of a three-wait-state store
        req[2] = 1'b1; we[2] = 1'b1; bo[2] = 1'b0; addr[2] = 32'h30; wd[2] = 32'h0BADBEEF;
        exp_busy[2] = 1'b1;
        @(posedge clk); #3;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ld_m[k] = 0; st_m[k] = 0;
        end
        exp_busy[2] = 1'b0;
        #1;
        post("t5_async_busy", 2, {31'b0, busy[2]}, 32'd0);
        go_idle(2);
        reset = 1'b0;
        post("t5_storecount", 2, {16'b0, stc[2]}, 32'd0);
        post("t5_loadcount", 2, {16'b0, ldc[2]}, 32'd0);
        access(2, 0, 0, 32'h30, 32'h0, 0);
        post("t5_oldvalue", 2, rd_seen[2], 32'hCAFEF00D);

        // Load counter saturation
        for (int i = 0; i < 65537; i++)
            access(0, 0, 1'($urandom), $urandom, 32'h0, 0);
        post("t6_saturate", 0, {16'b0, ldc[0]}, 32'h0000FFFF);
        post("t6_storecount", 0, {16'b0, stc[0]}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
